// File: rtl/video_sprite_motion_ctrl_if.sv
// Register-bus bundle for the sprite motion controller: write/read strobes,
// address, write data and the registered read data.
interface video_sprite_motion_ctrl_if;
    logic        cfg_we;
    logic        cfg_re;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;

    modport master (
        output cfg_we, cfg_re, cfg_addr, cfg_wdata,
        input  cfg_rdata
    );

    modport slave (
        input  cfg_we, cfg_re, cfg_addr, cfg_wdata,
        output cfg_rdata
    );
endinterface

// File: rtl/video_sprite_motion_ctrl.sv
// Vblank-synchronous sprite mover: steps the origin by a signed velocity every
// DIV+1 frames, bouncing or wrapping at the screen edges.
module video_sprite_motion_ctrl #(
    parameter int H_DISPLAY    = 640,
    parameter int V_DISPLAY    = 480,
    parameter int SPRITE_HSIZE = 32,
    parameter int SPRITE_VSIZE = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          vblank_tick,
    video_sprite_motion_ctrl_if.slave     cfg,
    output logic [31:0]                   x0,
    output logic [31:0]                   y0,
    output logic                          bypass,
    output logic                          edge_hit
);
    localparam logic signed [31:0] XMAX = 32'(H_DISPLAY - SPRITE_HSIZE);
    localparam logic signed [31:0] YMAX = 32'(V_DISPLAY - SPRITE_VSIZE);

    typedef enum logic [1:0] {IDLE, WAIT, CALC, COMMIT} state_t;

    state_t             state, state_nxt;
    logic [2:0]         ctrl;
    logic signed [15:0] dx, dy;
    logic [3:0]         div, div_cnt;
    logic [3:0]         flags;
    logic               pend_x, pend_y;
    logic [31:0]        pend_xv, pend_yv;
    logic signed [31:0] nx_p1, ny_p1;
    logic signed [31:0] x_edge, y_edge;
    logic [3:0]         hits;
    logic               neg_x, neg_y;
    logic               wr_ctrl, wr_xpos, wr_ypos, wr_vel, wr_div, wr_status;
    logic               enable_eff, commit_en, busy;
    logic [31:0]        rd_mux;

    function automatic logic signed [31:0] edge_pos(input logic signed [31:0] n,
                                                    input logic signed [31:0] lim,
                                                    input logic wrap);
        if (n < 0)
            edge_pos = wrap ? n + lim + 32'sd1 : -n;
        else if (n > lim)
            edge_pos = wrap ? n - lim - 32'sd1 : lim + lim - n;
        else
            edge_pos = n;
    endfunction

    function automatic logic crossed(input logic signed [31:0] n,
                                     input logic signed [31:0] lim);
        crossed = (n < 0) || (n > lim);
    endfunction

    assign wr_ctrl   = cfg.cfg_we && (cfg.cfg_addr == 3'd0);
    assign wr_xpos   = cfg.cfg_we && (cfg.cfg_addr == 3'd1);
    assign wr_ypos   = cfg.cfg_we && (cfg.cfg_addr == 3'd2);
    assign wr_vel    = cfg.cfg_we && (cfg.cfg_addr == 3'd3);
    assign wr_div    = cfg.cfg_we && (cfg.cfg_addr == 3'd4);
    assign wr_status = cfg.cfg_we && (cfg.cfg_addr == 3'd5);

    // A CTRL write in the same cycle takes effect immediately so that
    // disabling during CALC/COMMIT suppresses the pending commit.
    assign enable_eff = wr_ctrl ? cfg.cfg_wdata[0] : ctrl[0];
    assign busy       = (state == CALC) || (state == COMMIT);
    assign commit_en  = (state == COMMIT) && enable_eff;
    assign bypass     = ctrl[2] | ~ctrl[0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable_eff) state_nxt = WAIT;
            WAIT:    if (!enable_eff) state_nxt = IDLE;
                     else if (vblank_tick && (div_cnt == div)) state_nxt = CALC;
            CALC:    state_nxt = enable_eff ? COMMIT : IDLE;
            COMMIT:  state_nxt = enable_eff ? WAIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        x_edge = edge_pos(nx_p1, XMAX, ctrl[1]);
        y_edge = edge_pos(ny_p1, YMAX, ctrl[1]);
        neg_x  = !ctrl[1] && !pend_x && crossed(nx_p1, XMAX);
        neg_y  = !ctrl[1] && !pend_y && crossed(ny_p1, YMAX);
        hits   = {!pend_y && (ny_p1 >= YMAX), !pend_y && (ny_p1 <= 0),
                  !pend_x && (nx_p1 >= XMAX), !pend_x && (nx_p1 <= 0)};
    end

    always_comb begin
        rd_mux = '0;
        case (cfg.cfg_addr)
            3'd0:    rd_mux = {29'd0, ctrl};
            3'd1:    rd_mux = x0;
            3'd2:    rd_mux = y0;
            3'd3:    rd_mux = {dy, dx};
            3'd4:    rd_mux = {28'd0, div};
            3'd5:    rd_mux = {27'd0, flags, busy};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ctrl          <= '0;
            dx            <= '0;
            dy            <= '0;
            div           <= '0;
            div_cnt       <= '0;
            flags         <= '0;
            pend_x        <= 1'b0;
            pend_y        <= 1'b0;
            pend_xv       <= '0;
            pend_yv       <= '0;
            nx_p1         <= '0;
            ny_p1         <= '0;
            x0            <= '0;
            y0            <= '0;
            edge_hit      <= 1'b0;
            cfg.cfg_rdata <= '0;
        end else begin
            state         <= state_nxt;
            cfg.cfg_rdata <= cfg.cfg_re ? rd_mux : '0;
            edge_hit      <= commit_en && (|hits);
            flags         <= (wr_status ? 4'd0 : flags) | (commit_en ? hits : 4'd0);

            if (wr_ctrl) ctrl <= cfg.cfg_wdata[2:0];
            if (wr_div)  div  <= cfg.cfg_wdata[3:0];

            if (!enable_eff)
                div_cnt <= '0;
            else if ((state == WAIT) && vblank_tick)
                div_cnt <= (div_cnt == div) ? 4'd0 : div_cnt + 4'd1;

            // CALC -> COMMIT boundary: raw next position
            if (state == CALC) begin
                nx_p1 <= $signed(x0) + 32'(dx);
                ny_p1 <= $signed(y0) + 32'(dy);
            end

            if (wr_vel) begin
                dx <= cfg.cfg_wdata[15:0];
                dy <= cfg.cfg_wdata[31:16];
            end else if (commit_en) begin
                if (neg_x) dx <= -dx;
                if (neg_y) dy <= -dy;
            end

            if ((state == IDLE) && wr_xpos)
                x0 <= cfg.cfg_wdata;
            else if (commit_en)
                x0 <= pend_x ? pend_xv : x_edge;

            if ((state == IDLE) && wr_ypos)
                y0 <= cfg.cfg_wdata;
            else if (commit_en)
                y0 <= pend_y ? pend_yv : y_edge;

            if (wr_xpos && (state != IDLE)) begin
                pend_x  <= 1'b1;
                pend_xv <= cfg.cfg_wdata;
            end else if (commit_en) begin
                pend_x  <= 1'b0;
            end

            if (wr_ypos && (state != IDLE)) begin
                pend_y  <= 1'b1;
                pend_yv <= cfg.cfg_wdata;
            end else if (commit_en) begin
                pend_y  <= 1'b0;
            end
        end
    end
endmodule
